timer_ctrl: RTL
===============

# timer_ctrl

Controller that sequences a 4-bit up-counter as a programmable timer. Adds terminal-count compare, one-shot and periodic modes, pause/resume and abort to the bare counter. Produces a registered terminal-count pulse and a done flag for downstream logic. Sits between software-style control strobes and the counter datapath; it is the sole owner of the counter's enable and clear.

## Interface
- WIDTH, 4, counter and terminal-count width
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- cfg_we  in  1  write cfg_tc/cfg_periodic; honoured only in IDLE or DONE
- cfg_tc  in  WIDTH  terminal count; period = cfg_tc+1 cycles
- cfg_periodic  in  1  1 = periodic reload, 0 = one-shot
- start  in  1  single-cycle strobe: begin (IDLE/DONE) or resume (PAUSE)
- stop  in  1  single-cycle strobe: pause (RUN) or abort (PAUSE/DONE)
- cnt  out  WIDTH  current count
- busy  out  1  high in RUN or PAUSE
- done  out  1  high in DONE (one-shot completed)
- tc_pulse  out  1  one-cycle registered pulse on each terminal count

## Operation
- Registers: state, tc_reg (reset all-ones = 15), per_reg (reset 0), tc_pulse.
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE, cnt=0, busy=0, done=0, tc_pulse=0.
- IDLE: cnt held at 0. start → RUN, cnt=0.
- RUN: cnt increments by 1 per cycle. When cnt==tc_reg at an edge:
  - periodic: cnt→0, tc_pulse→1, stay RUN.
  - one-shot: cnt holds tc_reg, tc_pulse→1, → DONE.
- RUN + stop → PAUSE, cnt frozen.
- PAUSE: start → RUN, counting resumes from the frozen value. stop → IDLE, cnt→0.
- DONE: cnt holds tc_reg. start → RUN with cnt=0. stop → IDLE with cnt=0.
- Priority: stop beats start in every state. stop beats the terminal event in RUN: no tc_pulse, go PAUSE.
- cfg_we in RUN or PAUSE is ignored; tc_reg and per_reg are unchanged.
- cfg_we together with start in IDLE/DONE: the new config is latched on the same edge and governs the run.
- tc_reg=0: one-shot finishes on the first RUN compare; periodic pulses every cycle.
- Arithmetic is unsigned WIDTH-bit. cnt never exceeds tc_reg during RUN, so no natural wrap occurs. Writes to tc_reg happen only outside RUN/PAUSE.
- Asynchronous reset mid-operation clears every register immediately, including tc_reg→15 and per_reg→0.

## Timing
- start sampled at edge k → busy=1 and cnt=0 after k; cnt=n after edge k+n.
- Terminal compare at edge k+tc: tc_pulse is high for exactly the cycle after it.
  - periodic: tc_pulse coincides with cnt=0.
  - one-shot: tc_pulse coincides with done=1, busy=0, cnt=tc.
- Periodic pulses are spaced exactly tc_reg+1 cycles apart.
- stop sampled at edge k → PAUSE after k. The cnt value after k equals the value before k.
- All outputs are registered or decoded directly from state; there are no combinational paths from inputs to outputs.

## Structure
- Shared package timer_pkg holds the state encodings (IDLE=0, RUN=1, PAUSE=2, DONE=3, 2-bit) and the default WIDTH.
- One sub-module, counter_core:
  - Ports: clk, rstn, en, clr, load_hold (no-op hold), out[WIDTH].
  - Behaviour: clr has priority over en.
- timer_ctrl contains the FSM, config registers, compare logic and tc_pulse register, and drives counter_core's en/clr.

## Test plan
- Reset: rstn=0 for 20 ns with clk running → cnt=0, busy=0, done=0, tc_pulse=0. A subsequent start with no cfg counts 0..15 then sets done.
- One-shot: cfg_tc=7, cfg_periodic=0, then start → cnt 0..7 over 8 cycles. tc_pulse is high for one cycle with done=1 and cnt=7, and cnt stays 7.
- Periodic: cfg_tc=3, cfg_periodic=1, then start → cnt sequence 0,1,2,3,0,1,… with 3 tc_pulses in 12 cycles, spaced 4 apart. Busy stays 1.
- Pause/resume: one-shot cfg_tc=9, stop when cnt=4, hold 5 cycles → cnt=4 and busy=1 throughout. Then start → counting continues 5..9 and done=1.
- Priority/abort:
  - start and stop together in IDLE → stays IDLE.
  - stop at the terminal cycle with cnt=tc → PAUSE and no tc_pulse.
  - A second stop → IDLE with cnt=0.
  - cfg_we with cfg_tc=2 during RUN → ignored; the run still ends at the old tc.
- Async reset mid-run: rstn low at cnt=5 between edges → cnt, busy and state clear with no clock edge. After release, start runs to tc=15.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: state encodings and default width shared by the timer block
package timer_pkg;
    localparam int DEFAULT_WIDTH = 4;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/counter_core.sv
// counter_core: WIDTH-bit up-counter with clear and increment enable
//   clk, rstn  clock, asynchronous active-low reset
//   en         increment by one this cycle
//   clr        force to zero; wins over en
//   load_hold  freeze the value even when en is high
//   out        current count
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic             load_hold,
    output logic [WIDTH-1:0] out
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            out <= '0;
        else
            out <= clr ? '0 : (en && !load_hold) ? out + 1'b1 : out;
    end
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable one-shot/periodic timer around counter_core
//   clk, rstn     clock, asynchronous active-low reset
//   cfg_we        latch cfg_tc/cfg_periodic (IDLE or DONE only)
//   cfg_tc        terminal count, period is cfg_tc+1 cycles
//   cfg_periodic  1 reload at terminal count, 0 stop in DONE
//   start, stop   control strobes; stop wins over start and terminal count
//   cnt           current count
//   busy, done    RUN/PAUSE and DONE decodes
//   tc_pulse      registered one-cycle pulse per terminal count
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_tc,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);
    state_t           state;
    logic [WIDTH-1:0] tc_reg;
    logic             per_reg;
    logic             hit;
    logic             term;
    logic             en;
    logic             clr;
    assign hit  = (cnt == tc_reg);
    // terminal event only counts when no stop arrives in the same cycle
    assign term = (state == RUN) && !stop && hit;
    assign en   = (state == RUN) && !stop && !hit;
    // IDLE holds zero; every fresh start, abort or periodic reload clears
    assign clr  = (state == IDLE)
                || (state == DONE && (start || stop))
                || (state == PAUSE && stop)
                || (term && per_reg);
    assign busy = (state == RUN) || (state == PAUSE);
    assign done = (state == DONE);
    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .clr      (clr),
        .load_hold(state == PAUSE),
        .out      (cnt)
    );
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tc_reg   <= '1;
            per_reg  <= 1'b0;
            tc_pulse <= 1'b0;
        end else begin
            tc_pulse <= term;
            if (cfg_we && (state == IDLE || state == DONE)) begin
                tc_reg  <= cfg_tc;
                per_reg <= cfg_periodic;
            end
            case (state)
                IDLE:  state <= (start && !stop) ? RUN : IDLE;
                RUN:   state <= stop ? PAUSE : (hit && !per_reg) ? DONE : RUN;
                PAUSE: state <= stop ? IDLE : start ? RUN : PAUSE;
                DONE:  state <= stop ? IDLE : start ? RUN : DONE;
            endcase
        end
    end
endmodule
